fractal_sync_cnt_local_rf: RTL and testbench

Counting local barrier register file for the fractal synchronization tree. It generalises the two-party pairing RF to barriers with a run-time participant count. Each register accumulates arrivals from N_PORTS request ports until a per-barrier threshold is reached, then pulses completion. It sits at a tree node in place of the pairwise local RF when more than two children share one barrier.

---
 rtl/fractal_sync_cnt_local_rf_pkg.sv | 31 +++
 rtl/fractal_sync_cnt_local_rf_if.sv | 40 ++++
 rtl/fractal_sync_cnt_reg.sv | 74 +++++++
 rtl/fractal_sync_cnt_local_rf.sv | 129 ++++++++++++
 tb/tb_fractal_sync_cnt_local_rf.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fractal_sync_cnt_local_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fractal_sync_pkg
// Description : Shared types and helpers for the counting local barrier RF.
//               rsp_t is the per-port response flag bundle.
//               cnt_state_t is the per-register barrier state.
//               local_idx() maps a request id to its local register index.
// Revision    : 1.0 - initial release
// ============================================================================
package fractal_sync_pkg;

    // Per-port response flags. At most one of them is set.
    typedef struct packed {
        logic id_err;
        logic thr_err;
        logic ovf;
    } rsp_t;

    // Per-register barrier state. WAIT means a barrier is partially arrived.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } cnt_state_t;

    // Bit 0 of the id is the level flag. It does not select a local register.
    function automatic int unsigned local_idx(input logic [31:0] id);
        return id >> 1;
    endfunction

endpackage : fractal_sync_pkg
`default_nettype wire

// File: rtl/fractal_sync_cnt_local_rf_if.sv
`default_nettype none
// ============================================================================
// Module      : fractal_sync_cnt_local_rf_if
// Description : Request/response bundle of the counting local barrier RF.
//               req_*     : per-port arrival requests (valid, id, threshold)
//               rsp_*     : per-port registered responses
//               done_o    : per-register completion pulse
//               pending_o : per-register partially-arrived flag
//               master    : drives the requests. slave : the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface fractal_sync_cnt_local_rf_if #(
    parameter int unsigned N_REGS    = 4,
    parameter int unsigned ID_WIDTH  = 3,
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned CNT_WIDTH = 3
);
    logic [N_PORTS-1:0]                req_valid_i;
    logic [N_PORTS-1:0][ID_WIDTH-1:0]  req_id_i;
    logic [N_PORTS-1:0][CNT_WIDTH-1:0] req_thr_i;
    logic [N_PORTS-1:0]                rsp_valid_o;
    logic [N_PORTS-1:0]                rsp_id_err_o;
    logic [N_PORTS-1:0]                rsp_thr_err_o;
    logic [N_PORTS-1:0]                rsp_ovf_o;
    logic [N_REGS-1:0]                 done_o;
    logic [N_REGS-1:0]                 pending_o;

    modport master (
        output req_valid_i, req_id_i, req_thr_i,
        input  rsp_valid_o, rsp_id_err_o, rsp_thr_err_o, rsp_ovf_o,
        input  done_o, pending_o
    );

    modport slave (
        input  req_valid_i, req_id_i, req_thr_i,
        output rsp_valid_o, rsp_id_err_o, rsp_thr_err_o, rsp_ovf_o,
        output done_o, pending_o
    );
endinterface : fractal_sync_cnt_local_rf_if
`default_nettype wire

// File: rtl/fractal_sync_cnt_reg.sv
`default_nettype none
// ============================================================================
// Module      : fractal_sync_cnt_reg
// Description : One counting barrier register (cnt / thr / pending state).
//               i_acc     : arrivals accepted for this register this cycle
//               i_thr_ref : threshold that governs this cycle's arrivals
//               o_done    : one-cycle completion pulse (registered)
//               o_pending : barrier partially arrived
//               o_cnt/o_thr : current count and latched threshold
// Revision    : 1.0 - initial release
// ============================================================================
module fractal_sync_cnt_reg
    import fractal_sync_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [CNT_WIDTH-1:0] i_acc,
    input  wire logic [CNT_WIDTH-1:0] i_thr_ref,
    output logic                      o_done,
    output logic                      o_pending,
    output logic [CNT_WIDTH-1:0]      o_cnt,
    output logic [CNT_WIDTH-1:0]      o_thr
);

    cnt_state_t           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt,   w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_thr,   w_thr_nxt;
    logic                 r_done,  w_done_nxt;
    logic [CNT_WIDTH:0]   w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_thr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_thr   <= w_thr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The sum is one bit wider so it can be compared exactly with thr_ref.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_thr_nxt   = r_thr;
        w_done_nxt  = 1'b0;
        w_sum       = {1'b0, r_cnt} + {1'b0, i_acc};
        if (i_acc != '0) begin
            if (w_sum == {1'b0, i_thr_ref}) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_thr_nxt   = '0;
            end else begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = w_sum[CNT_WIDTH-1:0];
                w_thr_nxt   = i_thr_ref;
            end
        end
    end

    assign o_done    = r_done;
    assign o_pending = (r_state == ST_WAIT);
    assign o_cnt     = r_cnt;
    assign o_thr     = r_thr;

endmodule : fractal_sync_cnt_reg
`default_nettype wire

// File: rtl/fractal_sync_cnt_local_rf.sv
`default_nettype none
// ============================================================================
// Module      : fractal_sync_cnt_local_rf
// Description : Counting local barrier register file. N_PORTS request ports
//               arrive at N_REGS barrier registers. Each barrier completes
//               once its threshold of arrivals has been collected.
//               clk_i / rst_i : clock, synchronous active-high reset
//               bus           : requests in, per-port responses and
//                               per-register done/pending out
// Revision    : 1.0 - initial release
// ============================================================================
module fractal_sync_cnt_local_rf
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_REGS    = 4,
    parameter int unsigned ID_WIDTH  = 3,
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    fractal_sync_cnt_local_rf_if.slave bus
);

    localparam int unsigned c_sel_w = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    if (N_PORTS < 1) begin : g_ports_chk
        $error("N_PORTS must be at least 1");
    end
    if (CNT_WIDTH < $clog2(N_PORTS + 1)) begin : g_cnt_width_chk
        $error("CNT_WIDTH too narrow to count N_PORTS arrivals");
    end

    logic [CNT_WIDTH-1:0] w_cnt     [N_REGS];
    logic [CNT_WIDTH-1:0] w_thr     [N_REGS];
    logic [CNT_WIDTH-1:0] w_thr_ref [N_REGS];
    logic [CNT_WIDTH-1:0] w_acc     [N_REGS];
    logic [N_REGS-1:0]    w_done;
    logic [N_REGS-1:0]    w_pend;
    rsp_t                 w_rsp     [N_PORTS];
    rsp_t                 r_rsp     [N_PORTS];
    logic [N_PORTS-1:0]   r_rsp_valid;

    // Ports are walked in ascending order. An IDLE register takes its
    // reference threshold from the first port with a usable request. A WAIT
    // register keeps its latched threshold. Arrivals are accepted until the
    // remaining count runs out, and later arrivals overflow.
    always_comb begin
        int unsigned      v_idx;
        logic [c_sel_w-1:0] v_sel;
        v_idx = 0;
        v_sel = '0;
        for (int r = 0; r < N_REGS; r++) begin
            w_thr_ref[r] = w_pend[r] ? w_thr[r] : '0;
            w_acc[r]     = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            w_rsp[p] = '0;
            v_idx    = local_idx(32'(bus.req_id_i[p]));
            v_sel    = v_idx[c_sel_w-1:0];
            if (bus.req_valid_i[p]) begin
                if (v_idx >= N_REGS) begin
                    w_rsp[p].id_err = 1'b1;
                end else if (bus.req_thr_i[p] == '0) begin
                    w_rsp[p].thr_err = 1'b1;
                end else begin
                    // A latched threshold is never zero, so zero marks "unset".
                    if (w_thr_ref[v_sel] == '0) begin
                        w_thr_ref[v_sel] = bus.req_thr_i[p];
                    end
                    if (bus.req_thr_i[p] != w_thr_ref[v_sel]) begin
                        w_rsp[p].thr_err = 1'b1;
                    end else if (({1'b0, w_cnt[v_sel]} + {1'b0, w_acc[v_sel]})
                                 < {1'b0, w_thr_ref[v_sel]}) begin
                        w_acc[v_sel] = w_acc[v_sel] + 1'b1;
                    end else begin
                        w_rsp[p].ovf = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < N_REGS; r++) begin : g_reg
        fractal_sync_cnt_reg #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_reg (
            .clk       (clk_i),
            .rst       (rst_i),
            .i_acc     (w_acc[r]),
            .i_thr_ref (w_thr_ref[r]),
            .o_done    (w_done[r]),
            .o_pending (w_pend[r]),
            .o_cnt     (w_cnt[r]),
            .o_thr     (w_thr[r])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                r_rsp[p] <= '0;
            end
        end else begin
            r_rsp_valid <= bus.req_valid_i;
            for (int p = 0; p < N_PORTS; p++) begin
                r_rsp[p] <= w_rsp[p];
            end
        end
    end

    always_comb begin
        bus.rsp_id_err_o  = '0;
        bus.rsp_thr_err_o = '0;
        bus.rsp_ovf_o     = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            bus.rsp_id_err_o[p]  = r_rsp[p].id_err;
            bus.rsp_thr_err_o[p] = r_rsp[p].thr_err;
            bus.rsp_ovf_o[p]     = r_rsp[p].ovf;
        end
    end

    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.done_o      = w_done;
    assign bus.pending_o   = w_pend;

endmodule : fractal_sync_cnt_local_rf
`default_nettype wire

// File: tb/tb_fractal_sync_cnt_local_rf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fractal_sync_cnt_local_rf
// Description : Self-checking bench for the counting local barrier RF.
//               Directed vector table followed by randomized traffic checked
//               against a behavioural barrier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fractal_sync_cnt_local_rf;

    localparam int unsigned NR = 4;
    localparam int unsigned IW = 4;   // wide enough to form out-of-range ids
    localparam int unsigned NP = 4;
    localparam int unsigned CW = 3;

    typedef struct {
        logic                   rst;
        logic [NP-1:0]          v;
        logic [NP-1:0][IW-1:0]  id;
        logic [NP-1:0][CW-1:0]  thr;
        logic [NP-1:0]          ev, eie, ete, eov;
        logic [NR-1:0]          ed, ep;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_cnt  [NR];
    int m_thr  [NR];
    int m_pend [NR];

    fractal_sync_cnt_local_rf_if #(
        .N_REGS(NR), .ID_WIDTH(IW), .N_PORTS(NP), .CNT_WIDTH(CW)
    ) bus ();

    fractal_sync_cnt_local_rf #(
        .N_REGS(NR), .ID_WIDTH(IW), .N_PORTS(NP), .CNT_WIDTH(CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v,
                                input int i0, input int i1, input int i2, input int i3,
                                input int t0, input int t1, input int t2, input int t3,
                                input logic [3:0] ev, input logic [3:0] eie,
                                input logic [3:0] ete, input logic [3:0] eov,
                                input logic [3:0] ed, input logic [3:0] ep);
        vec_t x;
        x.rst = r;  x.v = v;
        x.id[0] = 4'(i0); x.id[1] = 4'(i1); x.id[2] = 4'(i2); x.id[3] = 4'(i3);
        x.thr[0] = 3'(t0); x.thr[1] = 3'(t1); x.thr[2] = 3'(t2); x.thr[3] = 3'(t3);
        x.ev = ev; x.eie = eie; x.ete = ete; x.eov = eov; x.ed = ed; x.ep = ep;
        return x;
    endfunction

    // Behavioural barrier model: per register, gather the ports that address
    // it in port order and settle each against the barrier's threshold.
    task automatic model_step(inout vec_t x);
        int ref_thr, taken, idx;
        x.ev = '0; x.eie = '0; x.ete = '0; x.eov = '0; x.ed = '0; x.ep = '0;
        if (x.rst) begin
            for (int r = 0; r < NR; r++) begin
                m_cnt[r] = 0; m_thr[r] = 0; m_pend[r] = 0;
            end
        end else begin
            x.ev = x.v;
            for (int p = 0; p < NP; p++)
                if (x.v[p] && (int'(x.id[p]) / 2) >= NR) x.eie[p] = 1'b1;
            for (int r = 0; r < NR; r++) begin
                ref_thr = (m_pend[r] != 0) ? m_thr[r] : 0;
                taken   = 0;
                for (int p = 0; p < NP; p++) begin
                    idx = int'(x.id[p]) / 2;
                    if (x.v[p] && !x.eie[p] && idx == r) begin
                        if (x.thr[p] == 0 || (ref_thr != 0 && int'(x.thr[p]) != ref_thr)) begin
                            x.ete[p] = 1'b1;
                        end else begin
                            if (ref_thr == 0) ref_thr = int'(x.thr[p]);
                            if (m_cnt[r] + taken < ref_thr) taken++;
                            else x.eov[p] = 1'b1;
                        end
                    end
                end
                if (taken > 0) begin
                    if (m_cnt[r] + taken == ref_thr) begin
                        x.ed[r] = 1'b1; m_cnt[r] = 0; m_pend[r] = 0;
                    end else begin
                        m_cnt[r] += taken; m_thr[r] = ref_thr; m_pend[r] = 1;
                    end
                end
            end
            for (int r = 0; r < NR; r++) x.ep[r] = (m_pend[r] != 0);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        rst             = x.rst;
        bus.req_valid_i = x.v;
        bus.req_id_i    = x.id;
        bus.req_thr_i   = x.thr;
        @(posedge clk);
        #1;
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid_o),   32'(x.ev));
        chk({tag, ".id_err"},    32'(bus.rsp_id_err_o),  32'(x.eie));
        chk({tag, ".thr_err"},   32'(bus.rsp_thr_err_o), 32'(x.ete));
        chk({tag, ".ovf"},       32'(bus.rsp_ovf_o),     32'(x.eov));
        chk({tag, ".done"},      32'(bus.done_o),        32'(x.ed));
        chk({tag, ".pending"},   32'(bus.pending_o),     32'(x.ep));
    endtask

    vec_t tbl [$];

    initial begin
        vec_t x;
        bus.req_valid_i = '0;
        bus.req_id_i    = '0;
        bus.req_thr_i   = '0;

        // reset and idle
        tbl.push_back(mk(1,4'b0000, 0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0000));
        tbl.push_back(mk(0,4'b0000, 0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0000));
        // single barrier reg1 thr3: ports 0,1 now, port 3 two cycles later
        tbl.push_back(mk(0,4'b0011, 2,2,0,0, 3,3,0,0, 4'b0011,4'b0000,4'b0000,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(0,4'b0000, 0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(0,4'b1000, 0,0,0,2, 0,0,0,3, 4'b1000,4'b0000,4'b0000,4'b0000,4'b0010,4'b0000));
        tbl.push_back(mk(0,4'b0000, 0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0000));
        // same-cycle completion on reg2
        tbl.push_back(mk(0,4'b1111, 4,4,4,4, 4,4,4,4, 4'b1111,4'b0000,4'b0000,4'b0000,4'b0100,4'b0000));
        // overflow on reg0 thr2
        tbl.push_back(mk(0,4'b0111, 0,0,0,0, 2,2,2,0, 4'b0111,4'b0000,4'b0000,4'b0100,4'b0001,4'b0000));
        // id error and zero threshold
        tbl.push_back(mk(0,4'b0011, 10,0,0,0, 1,0,0,0, 4'b0011,4'b0001,4'b0010,4'b0000,4'b0000,4'b0000));
        // WAIT thr3, mismatched thr2 leaves count alone, then two more complete it
        tbl.push_back(mk(0,4'b0001, 2,0,0,0, 3,0,0,0, 4'b0001,4'b0000,4'b0000,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(0,4'b0001, 2,0,0,0, 2,0,0,0, 4'b0001,4'b0000,4'b0001,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(0,4'b0011, 2,2,0,0, 3,3,0,0, 4'b0011,4'b0000,4'b0000,4'b0000,4'b0010,4'b0000));
        // reset mid-barrier: the arrival during reset gets no response
        tbl.push_back(mk(0,4'b0011, 2,2,0,0, 3,3,0,0, 4'b0011,4'b0000,4'b0000,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(1,4'b0001, 2,0,0,0, 3,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0000));
        tbl.push_back(mk(0,4'b0001, 2,0,0,0, 3,0,0,0, 4'b0001,4'b0000,4'b0000,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(0,4'b0001, 2,0,0,0, 3,0,0,0, 4'b0001,4'b0000,4'b0000,4'b0000,4'b0000,4'b0010));
        tbl.push_back(mk(0,4'b0001, 2,0,0,0, 3,0,0,0, 4'b0001,4'b0000,4'b0000,4'b0000,4'b0010,4'b0000));
        // thr=1 on reg0 every cycle, reg3 thr2 alongside
        tbl.push_back(mk(0,4'b0011, 0,6,0,0, 1,2,0,0, 4'b0011,4'b0000,4'b0000,4'b0000,4'b0001,4'b1000));
        tbl.push_back(mk(0,4'b0001, 0,0,0,0, 1,0,0,0, 4'b0001,4'b0000,4'b0000,4'b0000,4'b0001,4'b1000));
        tbl.push_back(mk(0,4'b0011, 0,6,0,0, 1,2,0,0, 4'b0011,4'b0000,4'b0000,4'b0000,4'b1001,4'b0000));
        tbl.push_back(mk(0,4'b0001, 0,0,0,0, 1,0,0,0, 4'b0001,4'b0000,4'b0000,4'b0000,4'b0001,4'b0000));
        tbl.push_back(mk(0,4'b0000, 0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0000));
        // IDLE reference from lowest valid port; no restart in the completing cycle
        tbl.push_back(mk(0,4'b0111, 4,4,4,0, 0,2,3,0, 4'b0111,4'b0000,4'b0101,4'b0000,4'b0000,4'b0100));
        tbl.push_back(mk(0,4'b0011, 4,4,0,0, 2,2,0,0, 4'b0011,4'b0000,4'b0000,4'b0010,4'b0100,4'b0000));
        tbl.push_back(mk(0,4'b0000, 0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,4'b0000,4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            x.rst = (i == 0) || ($urandom_range(0, 79) == 0);
            x.v   = 4'($urandom);
            for (int p = 0; p < NP; p++) begin
                x.id[p]  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 7));
                x.thr[p] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7))
                                                        : 3'($urandom_range(1, 4));
            end
            model_step(x);
            apply(x, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fractal_sync_cnt_local_rf
`default_nettype wire
